// File: rtl/capture_buffer.sv
// capture_buffer
//   Triggered single-shot sample capture for a display path. After an arm
//   request, the block takes one sample as the edge-detector history, waits
//   for a level crossing (or an auto-mode timeout), then fills a DEPTH-entry
//   frame with decimated samples. It then holds the frame stable until the
//   next arm.
//
// Parameters
//   DATA_W  sample width in bits
//   DEPTH   samples per frame
//   TMO_W   auto-trigger timeout counter width
//
// Ports
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   sample_in     unsigned ADC sample
//   sample_valid  qualifies sample_in for one clk
//   trig_level    unsigned trigger threshold
//   trig_slope    1 = rising edge, 0 = falling edge
//   decim         keep 1 of every decim+1 valid samples during capture
//   auto_mode     1 = force a trigger when the timeout counter saturates
//   arm           single-cycle request to start an acquisition
//   data_display  registered frame array
//   frame_ready   level, data_display holds a complete stable frame
//   busy          high while priming, waiting for trigger or capturing
//   forced        last frame was started by timeout rather than a real edge
module capture_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [7:0]        decim,
  input  logic              auto_mode,
  input  logic              arm,
  output logic [DATA_W-1:0] data_display [0:DEPTH-1],
  output logic              frame_ready,
  output logic              busy,
  output logic              forced
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRIME     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   prev_r, prev_s;
  logic [TMO_W-1:0]    tmo_r, tmo_s;
  logic [7:0]          dec_cnt_r, dec_cnt_s;
  logic [7:0]          dec_lat_r, dec_lat_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                ready_s;
  logic                forced_s;
  logic                edge_hit_s;
  logic                tmo_hit_s;
  logic                wr_en_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [DATA_W-1:0]   wr_data_s;

  // Unsigned level-crossing test between the previous and current sample.
  function automatic logic is_edge(input logic [DATA_W-1:0] prev,
                                   input logic [DATA_W-1:0] cur,
                                   input logic [DATA_W-1:0] level,
                                   input logic              rising);
    logic hit;
    if (rising) begin
      hit = (prev < level) && (cur >= level);
    end else begin
      hit = (prev > level) && (cur <= level);
    end
    return hit;
  endfunction

  // Next-state, counter and frame-write decode.
  always_comb begin
    state_s    = state_r;
    prev_s     = prev_r;
    tmo_s      = tmo_r;
    dec_cnt_s  = dec_cnt_r;
    dec_lat_s  = dec_lat_r;
    idx_s      = idx_r;
    ready_s    = frame_ready;
    forced_s   = forced;
    wr_en_s    = 1'b0;
    wr_idx_s   = {IDX_W{1'b0}};
    wr_data_s  = sample_in;
    edge_hit_s = is_edge(prev_r, sample_in, trig_level, trig_slope);
    // Timeout fires on the valid sample that finds the counter saturated.
    tmo_hit_s  = auto_mode && (tmo_r == TMO_MAX);

    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (arm) begin
          state_s = ST_PRIME;
          ready_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      ST_PRIME: begin
        // First valid sample only seeds the edge history.
        if (sample_valid) begin
          prev_s  = sample_in;
          tmo_s   = {TMO_W{1'b0}};
          state_s = ST_WAIT_TRIG;
        end else begin
          state_s = ST_PRIME;
        end
      end

      ST_WAIT_TRIG: begin
        if (sample_valid) begin
          prev_s = sample_in;
          if (edge_hit_s || tmo_hit_s) begin
            // A real edge wins over a coincident timeout.
            forced_s  = ~edge_hit_s;
            wr_en_s   = 1'b1;
            wr_idx_s  = {IDX_W{1'b0}};
            dec_lat_s = decim;
            dec_cnt_s = 8'd0;
            idx_s     = IDX_ONE;
            state_s   = ST_CAPTURE;
          end else if (auto_mode) begin
            tmo_s = tmo_r + TMO_ONE;
          end else begin
            tmo_s = tmo_r;
          end
        end else begin
          prev_s = prev_r;
        end
      end

      ST_CAPTURE: begin
        if (sample_valid) begin
          // Counter compares before incrementing, so the (decim+1)-th valid
          // sample after the previous write is the one kept.
          if (dec_cnt_r == dec_lat_r) begin
            dec_cnt_s = 8'd0;
            wr_en_s   = 1'b1;
            wr_idx_s  = idx_r;
            if (idx_r == IDX_LAST) begin
              ready_s = 1'b1;
              state_s = ST_HOLD;
            end else begin
              idx_s = idx_r + IDX_ONE;
            end
          end else begin
            dec_cnt_s = dec_cnt_r + 8'd1;
          end
        end else begin
          dec_cnt_s = dec_cnt_r;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control state, counters and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      prev_r      <= {DATA_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      dec_cnt_r   <= 8'd0;
      dec_lat_r   <= 8'd0;
      idx_r       <= {IDX_W{1'b0}};
      frame_ready <= 1'b0;
      forced      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      prev_r      <= prev_s;
      tmo_r       <= tmo_s;
      dec_cnt_r   <= dec_cnt_s;
      dec_lat_r   <= dec_lat_s;
      idx_r       <= idx_s;
      frame_ready <= ready_s;
      forced      <= forced_s;
      busy        <= (state_s == ST_PRIME) || (state_s == ST_WAIT_TRIG) ||
                     (state_s == ST_CAPTURE);
    end
  end

  // Frame storage: one element written per accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_display[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      data_display[wr_idx_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer with default parameters.
// A behavioural model (sample counts and modular arithmetic) is compared to
// the DUT on every falling clock edge; directed literal checks pin the model.
module tb_capture_buffer;

  localparam int DW = 12;
  localparam int DP = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = 12'd0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] trig_level = 12'd0;
  logic          trig_slope = 1'b1;
  logic [7:0]    decim = 8'd0;
  logic          auto_mode = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] data_display [0:DP-1];
  logic          frame_ready;
  logic          busy;
  logic          forced;

  capture_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .decim        (decim),
    .auto_mode    (auto_mode),
    .arm          (arm),
    .data_display (data_display),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .forced       (forced)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_PRIME = 1, P_WAIT = 2, P_CAP = 3, P_HOLD = 4;

  int            m_phase = P_IDLE;
  logic [DW-1:0] m_prev = 12'd0;
  int            m_wait_n = 0;   // valid samples counted while waiting (auto mode)
  int            m_k = 0;        // valid samples since trigger
  int            m_d = 0;        // latched decimation
  logic [DW-1:0] m_mem [0:DP-1];
  logic          m_ready = 1'b0;
  logic          m_forced = 1'b0;

  // Inputs as seen by the DUT at the rising edge.
  logic          s_rst, s_valid, s_slope, s_auto, s_arm;
  logic [DW-1:0] s_sample, s_level;
  logic [7:0]    s_decim;

  always @(posedge clk) begin
    s_rst    <= rst;
    s_valid  <= sample_valid;
    s_sample <= sample_in;
    s_level  <= trig_level;
    s_slope  <= trig_slope;
    s_decim  <= decim;
    s_auto   <= auto_mode;
    s_arm    <= arm;
  end

  task automatic model_step();
    logic real_edge;
    logic timeout;
    int idx;
    if (s_rst) begin
      m_phase = P_IDLE; m_prev = 12'd0; m_wait_n = 0; m_k = 0; m_d = 0;
      m_ready = 1'b0; m_forced = 1'b0;
      for (int i = 0; i < DP; i++) m_mem[i] = 12'd0;
    end else begin
      case (m_phase)
        P_IDLE, P_HOLD: if (s_arm) begin m_phase = P_PRIME; m_ready = 1'b0; end
        P_PRIME: if (s_valid) begin m_prev = s_sample; m_wait_n = 0; m_phase = P_WAIT; end
        P_WAIT: if (s_valid) begin
          if (s_auto) m_wait_n++;
          real_edge = s_slope ? ((m_prev < s_level) && (s_sample >= s_level))
                              : ((m_prev > s_level) && (s_sample <= s_level));
          timeout = s_auto && (m_wait_n == 65536);
          m_prev = s_sample;
          if (real_edge || timeout) begin
            m_mem[0] = s_sample; m_forced = !real_edge;
            m_d = int'(s_decim); m_k = 0; m_phase = P_CAP;
          end
        end
        P_CAP: if (s_valid) begin
          m_k++;
          if (m_k % (m_d + 1) == 0) begin
            idx = m_k / (m_d + 1);
            m_mem[idx] = s_sample;
            if (idx == DP - 1) begin m_ready = 1'b1; m_phase = P_HOLD; end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // Compare every cycle once the first rising edge has been seen.
  bit started = 1'b0;
  always @(negedge clk) begin
    int bad;
    if (started) begin
      model_step();
      chk("frame_ready", frame_ready, m_ready);
      chk("busy", busy, (m_phase == P_PRIME || m_phase == P_WAIT || m_phase == P_CAP));
      chk("forced", forced, m_forced);
      bad = -1;
      for (int i = 0; i < DP; i++)
        if (bad < 0 && data_display[i] !== m_mem[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL data_display[%0d]: got %0d expected %0d", bad, data_display[bad], m_mem[bad]);
      end
    end
  end
  always @(posedge clk) started <= 1'b1;

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [DW-1:0] s, input logic a);
    sample_valid = v; sample_in = s; arm = a;
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) drive(1'b0, 12'd0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 12'd0, 1'b0);
    chk("reset frame_ready", frame_ready, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset forced", forced, 1'b0);
    chk("reset data[0]", data_display[0], 12'd0);

    // Rising, level 2048, decim 0, ramp step 16.
    trig_level = 12'd2048; trig_slope = 1'b1; decim = 8'd0; auto_mode = 1'b0;
    drive(1'b0, 12'd0, 1'b1);
    for (int i = 0; i < 390; i++) drive(1'b1, 12'(16 * i), 1'b0);
    chk("ramp data[0]", data_display[0], 12'd2048);
    chk("ramp data[1]", data_display[1], 12'd2064);
    chk("ramp data[255]", data_display[255], 12'd2032);
    chk("ramp frame_ready", frame_ready, 1'b1);
    chk("ramp forced", forced, 1'b0);

    // Falling, level 1000, decim 3, ramp down from 1010; arm from HOLD.
    trig_level = 12'd1000; trig_slope = 1'b0; decim = 8'd3;
    drive(1'b0, 12'd0, 1'b1);
    chk("arm in hold clears ready", frame_ready, 1'b0);
    chk("arm in hold busy", busy, 1'b1);
    for (int i = 0; i < 1036; i++) begin
      if (i == 500) decim = 8'd0;   // must not affect the running frame
      drive(1'b1, 12'(1010 - i), 1'b0);
    end
    decim = 8'd3;
    chk("fall data[0]", data_display[0], 12'd1000);
    chk("fall data[1]", data_display[1], 12'd996);
    chk("fall data[255]", data_display[255], 12'd4076);
    chk("fall frame_ready", frame_ready, 1'b1);

    // Auto mode timeout with constant input 500.
    trig_level = 12'd2048; trig_slope = 1'b1; decim = 8'd0; auto_mode = 1'b1;
    drive(1'b0, 12'd0, 1'b1);
    for (int i = 0; i < 65536; i++) drive(1'b1, 12'd500, 1'b0);
    chk("auto pre-timeout data[0]", data_display[0], 12'd1000);
    chk("auto pre-timeout busy", busy, 1'b1);
    drive(1'b1, 12'd500, 1'b0);
    chk("auto timeout data[0]", data_display[0], 12'd500);
    chk("auto timeout forced", forced, 1'b1);
    for (int i = 0; i < 255; i++) drive(1'b1, 12'd500, 1'b0);
    chk("auto frame_ready", frame_ready, 1'b1);
    chk("auto data[255]", data_display[255], 12'd500);

    // Auto mode off: no frame.
    auto_mode = 1'b0;
    drive(1'b0, 12'd0, 1'b1);
    for (int i = 0; i < 2000; i++) drive(1'b1, 12'd500, 1'b0);
    chk("no-auto busy", busy, 1'b1);
    chk("no-auto frame_ready", frame_ready, 1'b0);
    chk("no-auto forced held", forced, 1'b1);
    rst = 1'b1;
    repeat (2) drive(1'b0, 12'd0, 1'b0);
    rst = 1'b0;

    // Valid toggling, decim 1, rising level 100, ramp of valid samples.
    trig_level = 12'd100; trig_slope = 1'b1; decim = 8'd1;
    drive(1'b0, 12'd0, 1'b1);
    c = 0;
    while (c <= 615) begin
      drive(1'b1, 12'(c), 1'b0);
      drive(1'b0, 12'hABC, 1'b0);
      c++;
    end
    chk("toggle data[0]", data_display[0], 12'd100);
    chk("toggle data[1]", data_display[1], 12'd102);
    chk("toggle data[255]", data_display[255], 12'd610);
    chk("toggle frame_ready", frame_ready, 1'b1);

    // Reset in the middle of capture; arm during capture and on reset ignored.
    trig_level = 12'd2048; decim = 8'd0;
    drive(1'b0, 12'd0, 1'b1);
    for (int i = 0; i <= 228; i++) drive(1'b1, 12'(16 * i), (i == 150));
    chk("mid-capture data[100]", data_display[100], 12'd3648);
    rst = 1'b1;
    drive(1'b1, 12'd5, 1'b1);
    chk("rst frame_ready", frame_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst forced", forced, 1'b0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < DP; i++) if (data_display[i] !== 12'd0) nz++;
      chk("rst nonzero elements", nz, 0);
    end
    rst = 1'b0;
    repeat (3) drive(1'b0, 12'd0, 1'b0);
    chk("arm on rst ignored", busy, 1'b0);

    // Boundary at the threshold: 2047 -> 2048 triggers, 2048 -> 2049 does not.
    drive(1'b0, 12'd0, 1'b1);
    drive(1'b1, 12'd2046, 1'b0);
    drive(1'b1, 12'd2047, 1'b0);
    drive(1'b1, 12'd2048, 1'b0);
    chk("2047->2048 trigger", data_display[0], 12'd2048);
    for (int i = 0; i < 255; i++) drive(1'b1, 12'd2049, 1'b0);
    chk("boundary frame_ready", frame_ready, 1'b1);
    drive(1'b0, 12'd0, 1'b1);
    drive(1'b1, 12'd2048, 1'b0);
    repeat (3) drive(1'b1, 12'd2049, 1'b0);
    chk("2048->2049 no trigger", data_display[0], 12'd2048);
    chk("2048->2049 busy", busy, 1'b1);
    chk("2048->2049 frame_ready", frame_ready, 1'b0);

    drive(1'b0, 12'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
